note_sequencer: RTL

// - Upstream stage of the PWM audio synth core: plays a programmed pattern of notes and drives the

---
 rtl/audio_pkg.sv | 25 ++
 rtl/seq_pattern_ram.sv | 32 +++
 rtl/note_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: constants and types shared by the PWM synth core and the
// note sequencer that feeds it.
package audio_pkg;

    // Widths of the synth core inputs driven by the sequencer.
    localparam int FREQ_W  = 12;
    localparam int LEN_W   = 3;
    localparam int ENTRY_W = 1 + LEN_W + FREQ_W;

    // One pattern step as stored in the pattern RAM and written by the host.
    typedef struct packed {
        logic              rest;
        logic [LEN_W-1:0]  len;
        logic [FREQ_W-1:0] freq;
    } seq_entry_t;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/seq_pattern_ram.sv
// seq_pattern_ram: STEPS-deep pattern store with one synchronous write port
// and one registered read port. A read and write to the same address in the
// same cycle returns the old entry.
module seq_pattern_ram
    import audio_pkg::*;
#(
    parameter int STEPS  = 16,
    parameter int ADDR_W = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  seq_entry_t        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output seq_entry_t        rd_data
);

    // NOTE: the storage array has no reset; the host must program every step
    // it plays, and leaving it unreset lets synthesis map it onto RAM cells.
    seq_entry_t mem [STEPS];

    // Write the addressed entry and register the read data every cycle.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make the read below see the entry
        // as it was before this edge's write, giving read-old-data behaviour.
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: plays a host-programmed pattern of notes, paced by a tempo
// divider, and drives the synth core's frequency, note-length and trigger
// inputs. Each step lasts (len+1) ticks of max(tempo_div,1) clocks plus one
// fetch cycle.
module note_sequencer
    import audio_pkg::*;
#(
    parameter int STEPS   = 16,
    parameter int TEMPO_W = 16,
    parameter int ADDR_W  = $clog2(STEPS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               run,
    input  logic               loop_en,
    input  logic [ADDR_W-1:0]  last_step,
    input  logic [TEMPO_W-1:0] tempo_div,
    output logic [FREQ_W-1:0]  frequency,
    output logic [LEN_W-1:0]   note_length,
    output logic               trigger,
    output logic [ADDR_W-1:0]  step_idx,
    output logic               busy,
    output logic               done
);

    // State codes kept as plain constants so the state register stays a
    // simple vector; values track the shared enum.
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_FETCH = FETCH;
    localparam logic [1:0] ST_PLAY  = PLAY;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]         state;
    logic [1:0]         state_d;
    logic [ADDR_W-1:0]  step_idx_d;

    // Pattern configuration captured when playback starts.
    logic [ADDR_W-1:0]  last_step_q;
    logic               loop_q;

    // Entry read from the pattern RAM and the length of the step in play.
    seq_entry_t         ram_q;
    logic [LEN_W-1:0]   cur_len;

    // Tempo and duration counters.
    logic [TEMPO_W-1:0] tick_cnt;
    logic [TEMPO_W-1:0] tick_limit;
    logic [LEN_W-1:0]   dur_cnt;
    logic               tick_wrap;
    logic               step_end;
    logic               at_last;
    logic               playing;
    logic               fetching;

    // The RAM is addressed with the next step index, so the entry for a new
    // step is already registered when the FSM enters FETCH.
    seq_pattern_ram #(
        .STEPS  (STEPS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (seq_entry_t'(wr_data)),
        .rd_addr (step_idx_d),
        .rd_data (ram_q)
    );

    // A tempo_div of zero behaves like one: a tick on every PLAY cycle.
    // Comparing with >= means a tempo lowered mid-tick wraps at once instead
    // of running the counter all the way round.
    assign tick_limit = (tempo_div == '0) ? '0 : tempo_div - TEMPO_W'(1);
    assign tick_wrap  = (tick_cnt >= tick_limit);
    assign step_end   = tick_wrap && (dur_cnt == cur_len);
    assign at_last    = (step_idx == last_step_q);
    assign playing    = (state == ST_PLAY)  && run;
    assign fetching   = (state == ST_FETCH) && run;
    assign busy       = (state == ST_FETCH) || (state == ST_PLAY);

    // Next-state and next-step-index decode.
    always_comb begin
        // NOTE: default every always_comb output first so no path through
        // the case statement can leave a latch behind.
        state_d    = state;
        step_idx_d = step_idx;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_d    = ST_FETCH;
                    step_idx_d = '0;
                end
            end
            ST_FETCH: begin
                if (!run) begin
                    state_d    = ST_IDLE;
                    step_idx_d = '0;
                end else begin
                    state_d    = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (!run) begin
                    state_d    = ST_IDLE;
                    step_idx_d = '0;
                end else if (step_end) begin
                    if (!at_last) begin
                        state_d    = ST_FETCH;
                        step_idx_d = step_idx + ADDR_W'(1);
                    end else if (loop_q) begin
                        state_d    = ST_FETCH;
                        step_idx_d = '0;
                    end else begin
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Hold until run is released; no automatic restart.
                if (!run) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                step_idx_d = '0;
            end
        endcase
    end

    // State, step index and the pattern configuration sampled at start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            step_idx    <= '0;
            last_step_q <= '0;
            loop_q      <= 1'b0;
        end else begin
            state    <= state_d;
            step_idx <= step_idx_d;
            if ((state == ST_IDLE) && run) begin
                last_step_q <= last_step;
                loop_q      <= loop_en;
            end
        end
    end

    // Tick and duration counters: cleared on fetch, advanced during play.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            dur_cnt  <= '0;
        end else if (state == ST_FETCH) begin
            tick_cnt <= '0;
            dur_cnt  <= '0;
        end else if (playing) begin
            if (tick_wrap) begin
                tick_cnt <= '0;
                if (!step_end) begin
                    dur_cnt <= dur_cnt + LEN_W'(1);
                end
            end else begin
                tick_cnt <= tick_cnt + TEMPO_W'(1);
            end
        end
    end

    // Output registers: load the note on fetch, pulse trigger and done.
    always_ff @(posedge clk) begin
        if (reset) begin
            frequency   <= '0;
            note_length <= '0;
            cur_len     <= '0;
            trigger     <= 1'b0;
            done        <= 1'b0;
        end else begin
            trigger <= 1'b0;
            done    <= 1'b0;
            if (fetching) begin
                cur_len <= ram_q.len;
                trigger <= !ram_q.rest;
                // A rest keeps the previous note on the synth inputs.
                if (!ram_q.rest) begin
                    frequency   <= ram_q.freq;
                    note_length <= ram_q.len;
                end
            end
            if (playing && step_end && at_last && !loop_q) begin
                done <= 1'b1;
            end
        end
    end

endmodule
